// File: rtl/lsu_load_unit.sv
// Load-side memory stage: one load at a time, a single-beat AXI4 read, then lane
// extraction and sign/zero extension back to the pipeline.
module lsu_load_unit #(
    parameter logic [3:0]  AXI_ID   = 4'd0,
    parameter logic [31:0] ERR_DATA = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    input  logic        rlast,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on any posedge where valid && ready are both high;
    // a raised valid stays high, with its payload stable, until that transfer.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_RESP = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sext_q, sext_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_data_q, resp_data_d;

    logic        req_bad;
    logic [31:0] lane;
    logic [31:0] load_data;
    logic        unused_ok;

    assign req_bad = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00);

    assign lane      = rdata >> {addr_q[1:0], 3'b000};
    assign unused_ok = &{1'b0, rlast, lane[31:16]};

    always_comb begin
        load_data = rdata;
        case (size_q)
            2'b00:   load_data = {{24{sext_q & lane[7]}}, lane[7:0]};
            2'b01:   load_data = {{16{sext_q & lane[15]}}, lane[15:0]};
            default: load_data = rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        sext_d       = sext_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d = req_addr;
                    size_d = req_size;
                    sext_d = req_sext;
                    // Bad requests never reach the bus; they answer straight away.
                    if (req_bad) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = ERR_DATA;
                    end else begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (rvalid) begin
                    rready_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = (rresp != 2'b00);
                    resp_data_d  = (rresp != 2'b00) ? ERR_DATA : load_data;
                    state_d      = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0;
            size_q       <= 2'b00;
            sext_q       <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // araddr stays on the latched address through R: the CLINT decodes it in its data phase.
    assign req_ready  = (state_q == S_IDLE);
    assign araddr     = addr_q;
    assign arsize     = {1'b0, size_q};
    assign arvalid    = arvalid_q;
    assign arid       = AXI_ID;
    assign arlen      = 8'd0;
    assign arburst    = 2'b01;
    assign rready     = rready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = resp_data_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_lsu_load_unit.sv
// Directed bench for lsu_load_unit: a per-transaction AXI responder driver and
// one task per scenario, each comparing against hand-computed values.
module tb_lsu_load_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'h0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sext = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic        rlast = 1'b1;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // Observations from the most recent run_load
    logic [31:0] obs_data;
    logic        obs_err;
    int          obs_lat;
    int          obs_ar_cycles;
    int          obs_ar_hs;
    logic [31:0] obs_ar_addr;
    logic [2:0]  obs_ar_size;
    logic        obs_ar_changed;
    logic        obs_r_addr_bad;
    logic        obs_resp_changed;
    logic        obs_busy_ready;
    logic        obs_timeout;

    lsu_load_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_size(req_size), .req_sext(req_sext),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_err(resp_err),
        .araddr(araddr), .arvalid(arvalid), .arready(arready), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready), .rlast(rlast),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Issues one request and plays the AXI slave and the pipeline consumer.
    task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                            input logic [31:0] rd, input logic [1:0] rr,
                            input int ar_wait, input int resp_wait, input logic stray);
        int   cyc;
        int   n_ar;
        int   n_resp;
        logic done;
        logic last;
        obs_data = 32'h0; obs_err = 1'b0; obs_lat = 0; obs_ar_hs = 0;
        obs_ar_addr = 32'h0; obs_ar_size = 3'd0; obs_ar_changed = 1'b0;
        obs_r_addr_bad = 1'b0; obs_resp_changed = 1'b0; obs_busy_ready = 1'b0;
        req_addr = a; req_size = sz; req_sext = sx; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        cyc = 0; n_ar = 0; n_resp = 0; done = 1'b0; last = 1'b0;
        while (!done && cyc < 100) begin
            cyc++;
            arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; resp_ready = 1'b0;
            if (req_ready) obs_busy_ready = 1'b1;
            if (arvalid) begin
                n_ar++;
                if (n_ar == 1) begin
                    obs_ar_addr = araddr;
                    obs_ar_size = arsize;
                end else if (araddr !== obs_ar_addr || arsize !== obs_ar_size) begin
                    obs_ar_changed = 1'b1;
                end
                if (stray) begin
                    rvalid = 1'b1;
                    rdata  = 32'hDEAD_BEEF;
                end
                if (n_ar > ar_wait) begin
                    arready = 1'b1;
                    obs_ar_hs++;
                end
            end
            if (rready) begin
                if (araddr !== obs_ar_addr) obs_r_addr_bad = 1'b1;
                rvalid = 1'b1; rdata = rd; rresp = rr;
            end
            if (resp_valid) begin
                n_resp++;
                if (n_resp == 1) begin
                    obs_lat = cyc; obs_data = resp_data; obs_err = resp_err;
                end else if (resp_data !== obs_data || resp_err !== obs_err) begin
                    obs_resp_changed = 1'b1;
                end
                if (n_resp > resp_wait) begin
                    resp_ready = 1'b1;
                    last = 1'b1;
                end
            end
            @(posedge clk); #1;
            if (last) done = 1'b1;
        end
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00; resp_ready = 1'b0;
        obs_timeout   = !done;
        obs_ar_cycles = n_ar;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b expected 1", req_ready); end
        checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid: got %b expected 0", arvalid); end
        checks++; if (rready !== 1'b0) begin errors++; $display("FAIL rst_rready: got %b expected 0", rready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp_err: got %b expected 0", resp_err); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL rst_resp_data: got %h expected 0", resp_data); end
        checks++; if (araddr !== 32'h0) begin errors++; $display("FAIL rst_araddr: got %h expected 0", araddr); end
        checks++; if (arsize !== 3'd0) begin errors++; $display("FAIL rst_arsize: got %0d expected 0", arsize); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        checks++; if (arid !== 4'd0 || arlen !== 8'd0 || arburst !== 2'b01) begin errors++; $display("FAIL rst_ar_const: got id %h len %h burst %b expected 0 00 01", arid, arlen, arburst); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_clint();
        run_load(32'h0200_0048, 2'b10, 1'b0, 32'h0000_1234, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_timeout) begin errors++; $display("FAIL lw_timeout: got timeout expected completion"); end
        checks++; if (obs_data !== 32'h0000_1234) begin errors++; $display("FAIL lw_data: got %h expected 00001234", obs_data); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL lw_err: got %b expected 0", obs_err); end
        checks++; if (obs_ar_hs != 1) begin errors++; $display("FAIL lw_ar_count: got %0d expected 1", obs_ar_hs); end
        checks++; if (obs_ar_addr !== 32'h0200_0048) begin errors++; $display("FAIL lw_araddr: got %h expected 02000048", obs_ar_addr); end
        checks++; if (obs_ar_size !== 3'd2) begin errors++; $display("FAIL lw_arsize: got %0d expected 2", obs_ar_size); end
        checks++; if (obs_lat != 3) begin errors++; $display("FAIL lw_latency: got %0d expected 3", obs_lat); end
        checks++; if (obs_r_addr_bad !== 1'b0) begin errors++; $display("FAIL lw_r_araddr: got moved expected held"); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL lw_idle_after: got %b expected 1", req_ready); end
    endtask

    task automatic test_byte();
        run_load(32'h8000_0001, 2'b00, 1'b1, 32'h0000_80FF, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_data !== 32'hFFFF_FF80 || obs_timeout) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", obs_data); end
        checks++; if (obs_ar_size !== 3'd0) begin errors++; $display("FAIL lb_arsize: got %0d expected 0", obs_ar_size); end
        run_load(32'h8000_0001, 2'b00, 1'b0, 32'h0000_80FF, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_data !== 32'h0000_0080 || obs_timeout) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", obs_data); end
        run_load(32'h8000_0003, 2'b00, 1'b1, 32'h7F00_0000, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_data !== 32'h0000_007F || obs_timeout) begin errors++; $display("FAIL lb3_data: got %h expected 0000007f", obs_data); end
    endtask

    task automatic test_half();
        run_load(32'h8000_0002, 2'b01, 1'b0, 32'hBEEF_1234, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_data !== 32'h0000_BEEF || obs_timeout) begin errors++; $display("FAIL lhu_data: got %h expected 0000beef", obs_data); end
        checks++; if (obs_ar_size !== 3'd1) begin errors++; $display("FAIL lhu_arsize: got %0d expected 1", obs_ar_size); end
        run_load(32'h8000_0002, 2'b01, 1'b1, 32'hBEEF_1234, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_data !== 32'hFFFF_BEEF || obs_timeout) begin errors++; $display("FAIL lh_data: got %h expected ffffbeef", obs_data); end
        run_load(32'h8000_0000, 2'b01, 1'b1, 32'h1234_8001, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_data !== 32'hFFFF_8001 || obs_timeout) begin errors++; $display("FAIL lh0_data: got %h expected ffff8001", obs_data); end
    endtask

    task automatic test_misaligned();
        run_load(32'h0200_004A, 2'b10, 1'b0, 32'h1111_1111, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_err !== 1'b1 || obs_timeout) begin errors++; $display("FAIL mis_lw_err: got %b expected 1", obs_err); end
        checks++; if (obs_data !== 32'h0) begin errors++; $display("FAIL mis_lw_data: got %h expected 0", obs_data); end
        checks++; if (obs_ar_cycles != 0) begin errors++; $display("FAIL mis_lw_arvalid: got %0d cycles expected 0", obs_ar_cycles); end
        checks++; if (obs_lat != 1) begin errors++; $display("FAIL mis_lw_latency: got %0d expected 1", obs_lat); end
        run_load(32'h8000_0001, 2'b01, 1'b1, 32'h1111_1111, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_err !== 1'b1 || obs_ar_cycles != 0 || obs_timeout) begin errors++; $display("FAIL mis_lh: got err %b ar %0d expected err 1 ar 0", obs_err, obs_ar_cycles); end
        run_load(32'h8000_0000, 2'b11, 1'b0, 32'h1111_1111, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_err !== 1'b1 || obs_ar_cycles != 0 || obs_timeout) begin errors++; $display("FAIL size11: got err %b ar %0d expected err 1 ar 0", obs_err, obs_ar_cycles); end
    endtask

    task automatic test_bus_error_stall();
        run_load(32'h8000_0000, 2'b10, 1'b0, 32'h55AA_55AA, 2'b10, 4, 5, 1'b1);
        checks++; if (obs_err !== 1'b1 || obs_timeout) begin errors++; $display("FAIL berr_err: got %b expected 1", obs_err); end
        checks++; if (obs_data !== 32'h0) begin errors++; $display("FAIL berr_data: got %h expected 0", obs_data); end
        checks++; if (obs_ar_cycles != 5) begin errors++; $display("FAIL berr_ar_hold: got %0d cycles expected 5", obs_ar_cycles); end
        checks++; if (obs_ar_changed !== 1'b0 || obs_ar_addr !== 32'h8000_0000) begin errors++; $display("FAIL berr_ar_stable: got addr %h changed %b expected 80000000 0", obs_ar_addr, obs_ar_changed); end
        checks++; if (obs_resp_changed !== 1'b0) begin errors++; $display("FAIL berr_resp_stable: got changed expected held"); end
        checks++; if (obs_lat != 7) begin errors++; $display("FAIL berr_latency: got %0d expected 7", obs_lat); end
    endtask

    task automatic test_back_to_back();
        run_load(32'h8000_0010, 2'b10, 1'b0, 32'hA5A5_0001, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_data !== 32'hA5A5_0001 || obs_busy_ready !== 1'b0 || obs_timeout) begin errors++; $display("FAIL b2b_first: got %h busy_ready %b expected a5a50001 0", obs_data, obs_busy_ready); end
        run_load(32'h8000_0016, 2'b01, 1'b0, 32'h7654_3210, 2'b00, 1, 2, 1'b0);
        checks++; if (obs_data !== 32'h0000_7654 || obs_busy_ready !== 1'b0 || obs_timeout) begin errors++; $display("FAIL b2b_second: got %h busy_ready %b expected 00007654 0", obs_data, obs_busy_ready); end
    endtask

    task automatic test_stray_idle();
        for (int i = 0; i < 3; i++) begin
            rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
            @(posedge clk); #1;
            checks++; if (resp_valid !== 1'b0 || rready !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL stray_idle: got resp_valid %b rready %b req_ready %b expected 0 0 1", resp_valid, rready, req_ready); end
        end
        rvalid = 1'b0; rdata = 32'h0;
    endtask

    task automatic test_reset_mid();
        req_addr = 32'h8000_0004; req_size = 2'b10; req_sext = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        checks++; if (rready !== 1'b1) begin errors++; $display("FAIL rmid_in_r: got rready %b expected 1", rready); end
        rst = 1'b0;
        #1;
        checks++; if (rready !== 1'b0 || resp_valid !== 1'b0 || arvalid !== 1'b0) begin errors++; $display("FAIL rmid_clear: got rready %b resp_valid %b arvalid %b expected 0 0 0", rready, resp_valid, arvalid); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rmid_release: got req_ready %b resp_valid %b expected 1 0", req_ready, resp_valid); end
        run_load(32'h8000_0004, 2'b10, 1'b0, 32'hCAFE_F00D, 2'b00, 0, 0, 1'b0);
        checks++; if (obs_data !== 32'hCAFE_F00D || obs_err !== 1'b0 || obs_timeout) begin errors++; $display("FAIL rmid_after: got %h err %b expected cafef00d 0", obs_data, obs_err); end
    endtask

    initial begin
        test_reset();
        test_lw_clint();
        test_byte();
        test_half();
        test_misaligned();
        test_bus_error_stall();
        test_back_to_back();
        test_stray_idle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
